// File: rtl/gcd_arb_pkg.sv
// Shared types and default constants for the round-robin GCD arbiter.
package gcd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int GCD_W       = 4;
    localparam int GCD_TIMEOUT = 255;

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id
);

    // rot_idx[k] is the requester examined at priority rank k (rank 0 = ptr)
    logic [IW-1:0] rot_idx [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot_idx[gi] = IW'((int'(ptr) + gi) % N);
    end

    always_comb begin
        grant    = '0;
        grant_id = '0;
        // Scan from lowest to highest priority so the highest-priority hit wins
        for (int i = N - 1; i >= 0; i--) begin
            if (req[rot_idx[i]]) begin
                grant_id = rot_idx[i];
            end
        end
        if (|req) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD engine among N requesters; zero operands answered with an error.
// Optional WAIT timeout with eng_abort output enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = GCD_W
`ifdef GCD_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = GCD_TIMEOUT
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*W-1:0]       req_x,
    input  logic [N*W-1:0]       req_y,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_gcd,
    output logic                 rsp_err,
    output logic                 eng_go,
    output logic [W-1:0]         eng_x,
    output logic [W-1:0]         eng_y,
`ifdef GCD_ARB_TIMEOUT_EN
    output logic                 eng_abort,
`endif
    input  logic                 eng_done,
    input  logic [W-1:0]         eng_gcd
);

    localparam int IW = $clog2(N);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_LAUNCH = ST_LAUNCH;
    localparam logic [1:0] S_WAIT   = ST_WAIT;
    localparam logic [1:0] S_RESP   = ST_RESP;

    logic [1:0]    state_reg, state_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [IW-1:0] id_reg, id_next;
    logic [W-1:0]  x_reg, x_next;
    logic [W-1:0]  y_reg, y_next;
    logic [W-1:0]  gcd_reg, gcd_next;
    logic          err_reg, err_next;

    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic [W-1:0]  x_arr [N];
    logic [W-1:0]  y_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign x_arr[gi] = req_x[gi*W +: W];
        assign y_arr[gi] = req_y[gi*W +: W];
    end

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req      (req_valid),
        .ptr      (ptr_reg),
        .grant    (grant),
        .grant_id (grant_id)
    );

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timed_out;

    // A done arriving in the same cycle as the limit still wins
    assign timed_out = (state_reg == S_WAIT) && !eng_done && (cnt_reg == CNT_W'(TIMEOUT));
    assign eng_abort = timed_out;
`endif

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        id_next    = id_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        gcd_next   = gcd_reg;
        err_next   = err_reg;
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (|grant) begin
                    id_next    = grant_id;
                    x_next     = x_arr[grant_id];
                    y_next     = y_arr[grant_id];
                    gcd_next   = '0;
                    // Zero operand would never terminate the subtractive engine
                    err_next   = (x_arr[grant_id] == '0) || (y_arr[grant_id] == '0);
                    state_next = err_next ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
                cnt_next   = '0;
`endif
            end
            S_WAIT: begin
                if (eng_done) begin
                    gcd_next   = eng_gcd;
                    err_next   = 1'b0;
                    state_next = S_RESP;
                end
`ifdef GCD_ARB_TIMEOUT_EN
                else if (timed_out) begin
                    gcd_next   = '0;
                    err_next   = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            S_RESP: begin
                ptr_next   = (id_reg == IW'(N - 1)) ? '0 : id_reg + 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            ptr_reg   <= '0;
            id_reg    <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            gcd_reg   <= '0;
            err_reg   <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            id_reg    <= id_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            gcd_reg   <= gcd_next;
            err_reg   <= err_next;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_reg   <= cnt_next;
`endif
        end
    end

    assign req_ready = (state_reg == S_IDLE) ? grant : '0;
    assign eng_go    = (state_reg == S_LAUNCH);
    assign eng_x     = x_reg;
    assign eng_y     = y_reg;
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_id    = rsp_valid ? id_reg : '0;
    assign rsp_gcd   = rsp_valid ? gcd_reg : '0;
    assign rsp_err   = rsp_valid & err_reg;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: vector table plus arbitration, reset and timeout sequences.
module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_x = '0;
    logic [N*W-1:0] req_y = '0;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_gcd;
    logic           rsp_err;
    logic           eng_go;
    logic [W-1:0]   eng_x, eng_y;
    logic           eng_done = 1'b0;
    logic [W-1:0]   eng_gcd = '0;
`ifdef GCD_ARB_TIMEOUT_EN
    logic           eng_abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_arbiter #(
        .N(N),
        .W(W)
`ifdef GCD_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(20)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_gcd   (rsp_gcd),
        .rsp_err   (rsp_err),
        .eng_go    (eng_go),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
`ifdef GCD_ARB_TIMEOUT_EN
        .eng_abort (eng_abort),
`endif
        .eng_done  (eng_done),
        .eng_gcd   (eng_gcd)
    );

    function automatic logic [3:0] gcd_ref(input logic [3:0] a, input logic [3:0] b);
        int p = int'(a);
        int q = int'(b);
        while (p != q) begin
            if (p > q) p = p - q;
            else       q = q - p;
        end
        return 4'(p);
    endfunction

    // Engine model: done pulses eng_lat cycles after eng_go; not tied to the arbiter reset
    int         eng_lat  = 5;
    bit         eng_hang = 1'b0;
    bit         eng_busy = 1'b0;
    int         eng_cnt  = 0;
    logic [3:0] eng_a = '0, eng_b = '0;

    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (eng_go && !eng_hang) begin
            eng_busy <= 1'b1;
            eng_cnt  <= eng_lat - 1;
            eng_a    <= eng_x;
            eng_b    <= eng_y;
        end else if (eng_busy) begin
            if (eng_cnt <= 1) begin
                eng_done <= 1'b1;
                eng_gcd  <= gcd_ref(eng_a, eng_b);
                eng_busy <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    typedef struct {int cyc; logic [1:0] id; logic [3:0] gcd; logic err;} rsp_t;
    typedef struct {int cyc; logic [3:0] mask;} acc_t;
    typedef struct {int cyc; logic [3:0] x; logic [3:0] y;} go_t;

    rsp_t       rsp_q[$];
    acc_t       acc_q[$];
    go_t        go_q[$];
    int         abort_q[$];
    logic [3:0] hs_mask = '0;

    always @(negedge clk) begin
        hs_mask = req_valid & req_ready;
        if (rsp_valid) rsp_q.push_back(rsp_t'{cyc, rsp_id, rsp_gcd, rsp_err});
        if (|req_ready) acc_q.push_back(acc_t'{cyc, req_ready});
        if (eng_go) go_q.push_back(go_t'{cyc, eng_x, eng_y});
`ifdef GCD_ARB_TIMEOUT_EN
        if (eng_abort) abort_q.push_back(cyc);
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle; requesters whose handshake just completed drop valid
    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs_mask;
    endtask

    task automatic clear_q();
        rsp_q.delete();
        acc_q.delete();
        go_q.delete();
        abort_q.delete();
    endtask

    task automatic set_req(input int id, input int x, input int y);
        req_x[id*W +: W] = 4'(x);
        req_y[id*W +: W] = 4'(y);
        req_valid[id]    = 1'b1;
    endtask

    task automatic wait_rsp(input int n, input int lim);
        for (int i = 0; i < lim && rsp_q.size() < n; i++) step();
        if (rsp_q.size() < n) check("rsp_count_timeout", rsp_q.size(), n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    function automatic int oh_id(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_gcd"}, rsp_gcd, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_eng_go"}, eng_go, 0);
        check({tag, "_eng_x"}, eng_x, 0);
        check({tag, "_eng_y"}, eng_y, 0);
    endtask

    typedef struct {int id; int x; int y; int gcd; int err;} vec_t;
    vec_t vecs[7];

    initial begin
        int ids[3];
        int gcds[3];
        int exp_lat;

        vecs[0] = '{0, 12,  8, 4, 0};
        vecs[1] = '{1, 15, 10, 5, 0};
        vecs[2] = '{2,  7,  7, 7, 0};
        vecs[3] = '{3,  0,  9, 0, 1};
        vecs[4] = '{0,  9,  0, 0, 1};
        vecs[5] = '{2, 13,  5, 1, 0};
        vecs[6] = '{1, 15,  1, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // Single-requester vectors: grant, latency, engine launch and response fields
        for (int i = 0; i < 7; i++) begin
            clear_q();
            set_req(vecs[i].id, vecs[i].x, vecs[i].y);
            wait_rsp(1, 40);
            repeat (3) step();
            exp_lat = (vecs[i].err != 0) ? 1 : 7;
            check($sformatf("v%0d_go_count", i), go_q.size(), (vecs[i].err != 0) ? 0 : 1);
            if (acc_q.size() == 0 || rsp_q.size() == 0) begin
                check($sformatf("v%0d_handshake_seen", i), 0, 1);
            end else begin
                check($sformatf("v%0d_ready", i), acc_q[0].mask, 1 << vecs[i].id);
                check($sformatf("v%0d_latency", i), rsp_q[0].cyc - acc_q[0].cyc, exp_lat);
                check($sformatf("v%0d_rsp_id", i), rsp_q[0].id, vecs[i].id);
                check($sformatf("v%0d_rsp_gcd", i), rsp_q[0].gcd, vecs[i].gcd);
                check($sformatf("v%0d_rsp_err", i), rsp_q[0].err, vecs[i].err);
                if (go_q.size() != 0) begin
                    check($sformatf("v%0d_go_delay", i), go_q[0].cyc - acc_q[0].cyc, 1);
                    check($sformatf("v%0d_eng_x", i), go_q[0].x, vecs[i].x);
                    check($sformatf("v%0d_eng_y", i), go_q[0].y, vecs[i].y);
                end
                $display("[TB] txn id=%0d x=%0d y=%0d -> gcd=%0d err=%0d", rsp_q[0].id,
                         vecs[i].x, vecs[i].y, rsp_q[0].gcd, rsp_q[0].err);
            end
        end

        // Req1 and req2 together from pointer 0; req1 re-raised during service
        do_reset();
        clear_q();
        set_req(1, 15, 10);
        set_req(2, 12, 8);
        for (int i = 0; i < 10 && acc_q.size() == 0; i++) step();
        set_req(1, 9, 6);
        wait_rsp(3, 100);
        repeat (2) step();
        ids  = '{1, 2, 1};
        gcds = '{5, 4, 3};
        for (int i = 0; i < 3; i++) begin
            if (i < acc_q.size()) check($sformatf("rr_acc%0d_id", i), oh_id(acc_q[i].mask), ids[i]);
            if (i < rsp_q.size()) begin
                check($sformatf("rr_rsp%0d_id", i), rsp_q[i].id, ids[i]);
                check($sformatf("rr_rsp%0d_gcd", i), rsp_q[i].gcd, gcds[i]);
                $display("[TB] txn id=%0d gcd=%0d err=%0d", rsp_q[i].id, rsp_q[i].gcd, rsp_q[i].err);
            end
        end

        // All requesters continuously valid: service order 0,1,2,3,0,1,2,3
        do_reset();
        clear_q();
        set_req(0, 15, 10);
        set_req(1, 7, 7);
        set_req(2, 12, 8);
        set_req(3, 9, 6);
        for (int i = 0; i < 300 && rsp_q.size() < 8; i++) begin
            req_valid = '1;
            step();
        end
        req_valid = '0;
        check("all_rsp_count", rsp_q.size(), 8);
        gcds = '{5, 7, 4};
        for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
            check($sformatf("all_rsp%0d_id", i), rsp_q[i].id, i % 4);
            check($sformatf("all_rsp%0d_gcd", i), rsp_q[i].gcd, ((i % 4) == 3) ? 3 : gcds[i % 4]);
            $display("[TB] txn id=%0d gcd=%0d err=%0d", rsp_q[i].id, rsp_q[i].gcd, rsp_q[i].err);
        end
        repeat (10) step();

        // Reset during WAIT drops the transaction; pointer returns to 0
        do_reset();
        clear_q();
        set_req(1, 15, 10);
        wait_rsp(1, 40);
        step();
        clear_q();
        eng_lat = 12;
        set_req(2, 12, 8);
        for (int i = 0; i < 20 && go_q.size() == 0; i++) step();
        check("wr_go_seen", go_q.size(), 1);
        repeat (3) step();
        #2;
        rst = 1'b1;
        req_valid = '0;
        #1;
        check_outputs_zero("midrst");
        step();
        step();
        rst = 1'b0;
        repeat (15) step();
        check("wr_no_rsp_after_rst", rsp_q.size(), 0);
        eng_lat = 5;
        clear_q();
        set_req(0, 9, 6);
        set_req(3, 15, 10);
        wait_rsp(2, 60);
        if (acc_q.size() != 0) check("wr_first_grant", oh_id(acc_q[0].mask), 0);
        if (rsp_q.size() >= 2) begin
            check("wr_rsp0_id", rsp_q[0].id, 0);
            check("wr_rsp0_gcd", rsp_q[0].gcd, 3);
            check("wr_rsp1_id", rsp_q[1].id, 3);
            check("wr_rsp1_gcd", rsp_q[1].gcd, 5);
            $display("[TB] txn id=%0d gcd=%0d err=%0d", rsp_q[1].id, rsp_q[1].gcd, rsp_q[1].err);
        end
        req_valid = '0;
        repeat (3) step();

`ifdef GCD_ARB_TIMEOUT_EN
        // Engine never finishes: abort 20 cycles after WAIT entry, then error response
        clear_q();
        eng_hang = 1'b1;
        set_req(2, 12, 8);
        wait_rsp(1, 60);
        check("to_abort_count", abort_q.size(), 1);
        if (abort_q.size() != 0 && go_q.size() != 0 && rsp_q.size() != 0) begin
            check("to_abort_delay", abort_q[0] - go_q[0].cyc, 21);
            check("to_rsp_after_abort", rsp_q[0].cyc - abort_q[0], 1);
            check("to_rsp_err", rsp_q[0].err, 1);
            check("to_rsp_gcd", rsp_q[0].gcd, 0);
            $display("[TB] txn id=%0d timeout err=%0d", rsp_q[0].id, rsp_q[0].err);
        end
        eng_hang = 1'b0;
        repeat (3) step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
